// File: rtl/tmp_conv_ctrl.sv
// Conversion sequencer for the temperature-sensor switched-capacitor front-end.
// One start runs a precharge followed by N_CYCLES two-phase charge cycles.
// The comparator steers each cycle's charge polarity. The number of
// comparator-high decisions is returned on code with a one-clock valid.
// Every output is a flop, so the analog switches never see a combinational glitch.
module tmp_conv_ctrl #(
    parameter int N_CYCLES = 64,
    parameter int CODE_W   = 7,
    parameter int PRE_CYC  = 4,
    parameter int PH_CYC   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp,
    output logic              preChrg,
    output logic              PI1,
    output logic              PI2,
    output logic              PA,
    output logic              PB,
    output logic              PC,
    output logic              PD,
    output logic              busy,
    output logic              valid,
    output logic [CODE_W-1:0] code
);

    // One timer serves both the precharge and the phase durations.
    localparam int TMR_MAX = (PRE_CYC > PH_CYC) ? PRE_CYC : PH_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int K_W     = $clog2(N_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHG,
        S_GAP1,
        S_PH1,
        S_GAP2,
        S_PH2,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [CODE_W-1:0]   count_q, count_d;
    logic                bit_q, bit_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                cmp_meta_q, cmp_s_q;
    logic                pre_chrg_q, pi1_q, pi2_q, pa_q, pb_q, pc_q, pd_q;
    logic                busy_q, valid_q;
    logic                pre_chrg_d, pi1_d, pi2_d, pa_d, pb_d, pc_d, pd_d;
    logic                busy_d, valid_d;

    // Next state, counters and the registered-output image of the next state.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        k_d     = k_q;
        count_d = count_q;
        bit_d   = bit_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRECHG;
                    tmr_d   = '0;
                    k_d     = '0;
                    count_d = '0;
                    bit_d   = 1'b0;
                end
            end
            S_PRECHG: begin
                if (tmr_q == TMR_W'(PRE_CYC - 1)) begin
                    state_d = S_GAP1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_GAP1: begin
                state_d = S_PH1;
                tmr_d   = '0;
            end
            S_PH1: begin
                if (tmr_q == TMR_W'(PH_CYC - 1)) begin
                    state_d = S_GAP2;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_GAP2: begin
                state_d = S_PH2;
                tmr_d   = '0;
            end
            S_PH2: begin
                if (tmr_q == TMR_W'(PH_CYC - 1)) begin
                    // The decision taken here steers the next cycle.
                    bit_d   = cmp_s_q;
                    count_d = count_q + CODE_W'(cmp_s_q);
                    k_d     = k_q + K_W'(1);
                    tmr_d   = '0;
                    state_d = (k_q == K_W'(N_CYCLES - 1)) ? S_DONE : S_GAP1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // valid is a flop, so abort can only suppress it before DONE is entered.
        // Abort seen on the final PH2 clock therefore cancels the result as well.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            tmr_d   = '0;
        end

        pre_chrg_d = (state_d == S_PRECHG);
        pi1_d      = (state_d == S_PH1);
        pi2_d      = (state_d == S_PH2);
        pa_d       = (state_d == S_PH1) &&  bit_d;
        pc_d       = (state_d == S_PH1) && !bit_d;
        pb_d       = (state_d == S_PH2) &&  bit_d;
        pd_d       = (state_d == S_PH2) && !bit_d;
        busy_d     = (state_d != S_IDLE);
        valid_d    = (state_d == S_DONE);
        code_d     = (state_d == S_DONE) ? count_d : code_q;
    end

    // All state, the cmp synchroniser and the output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            k_q        <= '0;
            count_q    <= '0;
            bit_q      <= 1'b0;
            code_q     <= '0;
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
            pre_chrg_q <= 1'b0;
            pi1_q      <= 1'b0;
            pi2_q      <= 1'b0;
            pa_q       <= 1'b0;
            pb_q       <= 1'b0;
            pc_q       <= 1'b0;
            pd_q       <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            k_q        <= k_d;
            count_q    <= count_d;
            bit_q      <= bit_d;
            code_q     <= code_d;
            cmp_meta_q <= cmp;
            cmp_s_q    <= cmp_meta_q;
            pre_chrg_q <= pre_chrg_d;
            pi1_q      <= pi1_d;
            pi2_q      <= pi2_d;
            pa_q       <= pa_d;
            pb_q       <= pb_d;
            pc_q       <= pc_d;
            pd_q       <= pd_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign preChrg = pre_chrg_q;
    assign PI1     = pi1_q;
    assign PI2     = pi2_q;
    assign PA      = pa_q;
    assign PB      = pb_q;
    assign PC      = pc_q;
    assign PD      = pd_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign code    = code_q;

endmodule
